regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general register file for the pipelined CPU core, replacing the fixed 32x32, 2-read/1-write register file. It adds a second write port for late results from long-latency units (mult/div), per-byte write strobes, same-cycle write-to-read bypass on both ports, and a per-register pending scoreboard. Hazard logic uses the scoreboard to stall readers of in-flight results. It sits between the decode stage (reads), the writeback stage (write port 0) and the long-latency unit (write port 1).

## Interface
- DW, 32: data width in bits; a multiple of 8.
- AW, 5: address width; depth is 2^AW registers.
- NRD, 2: number of read ports.
- ZERO_REG, 1: when 1, register 0 reads 0, ignores writes and is never pending.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-low (reset==0 at a clk edge resets).
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*DW  read data, port k at [k*DW +: DW]; combinational, bypassed.
- rd_busy  out  NRD  pending flag of each read address; combinational, clear-bypassed.
- w0_en  in  1  write port 0 enable (writeback stage).
- w0_addr  in  AW  write port 0 address.
- w0_be  in  DW/8  write port 0 byte enables.
- w0_data  in  DW  write port 0 data.
- w1_en, w1_addr, w1_be, w1_data  in  1/AW/DW/8/DW  write port 1 (long-latency unit); same meaning as port 0.
- pend_set  in  1  mark register pend_addr pending at this edge.
- pend_addr  in  AW  register to mark pending.
- err_conflict  out  1  sticky flag: both write ports targeted the same address in one cycle.

## Operation
- Storage: 2^AW x DW registers plus a 2^AW-bit pending vector.
- Effective write: wN_en==1, reset==1, and not (ZERO_REG==1 and wN_addr==0). Only lanes with wN_be[b]==1 are updated.
- Same-address double write: apply port 1 lanes first, then port 0 lanes. Port 0 wins on overlapping lanes; non-overlapping lanes from both ports land. Set err_conflict at that edge; it stays 1 until reset.
- Read port k, combinational: start from the stored word, merge the effective port 1 lanes at rd_addr, then merge the effective port 0 lanes. With ZERO_REG==1 and rd_addr==0, output 0 regardless.
- Pending: pend[a] is cleared at an edge by any effective write to a (any be value, including all-zero). It is set by pend_set with pend_addr==a. Set and clear on the same a at the same edge: set wins.
- Pending with ZERO_REG==1: pend_set to address 0 is ignored.
- rd_busy[k] = pend[rd_addr_k] AND NOT (an effective write to rd_addr_k this cycle). The clear is bypassed; a pend_set in the current cycle is not visible until the next cycle.
- While reset==0: all writes and pend_set are ignored, bypass is disabled, and rd_data shows stored contents.

## Timing
- Reads and rd_busy: zero latency, combinational from rd_addr, the write ports and state.
- Writes, pend updates and err_conflict: take effect at the rising edge; visible in stored state from the next cycle.
- Reset edge (reset==0): every register becomes 0, all pend bits 0, err_conflict 0. From the following cycle, rd_data is 0 and rd_busy is 0 for every address.
- Reset mid-operation: any concurrent write or pend_set at that edge is discarded.
- No handshake. The core must hold w1 signals for exactly one cycle per result.

## Test plan
- Reset: write 0xDEADBEEF to r5, then drive reset=0 for one edge -> next cycle rd_data(r5)=0, rd_busy=0, err_conflict=0.
- Bypass and byte strobe: r3=0x11223344 stored; w0 to r3 with be=4'b0101, data 0xAABBCCDD in the same cycle as read of r3 -> rd_data=0x11BB33DD that cycle; stored value is 0x11BB33DD next cycle.
- Port conflict: w0 (be=4'b0011, 0x0000AAAA) and w1 (be=4'b1111, 0x55555555) both to r7 -> r7=0x5555AAAA, and err_conflict=1 permanently until reset.
- Scoreboard: pend_set r9 at cycle 0 -> rd_busy=1 for r9 from cycle 1. w1 to r9 at cycle 4 -> rd_busy=0 in cycle 4 with new data bypassed. pend_set and a write to r9 at the same edge -> r9 still pending.
- Zero register (ZERO_REG=1): w0 to r0 with 0xFFFFFFFF plus pend_set r0 -> rd_data(r0)=0 and rd_busy=0 in all cycles.
- Parameter sweep: DW=64, AW=4, NRD=3 -> all three ports read independent addresses correctly, and the 8 byte lanes write independently.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with byte strobes, write bypass and pending scoreboard
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              w0_en,
  input  logic [AW-1:0]     w0_addr,
  input  logic [DW/8-1:0]   w0_be,
  input  logic [DW-1:0]     w0_data,
  input  logic              w1_en,
  input  logic [AW-1:0]     w1_addr,
  input  logic [DW/8-1:0]   w1_be,
  input  logic [DW-1:0]     w1_data,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_addr,
  output logic              err_conflict
);
  localparam int DEPTH = 1 << AW;
  localparam int NB    = DW / 8;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;

  logic          w0_eff, w1_eff, same_addr, pend_ok;
  logic [DW-1:0] m0, m1, w1_word, w0_base, w0_word;

  always_comb begin
    m0 = '0;
    m1 = '0;
    for (int b = 0; b < NB; b++) begin
      m0[b*8 +: 8] = {8{w0_be[b]}};
      m1[b*8 +: 8] = {8{w1_be[b]}};
    end
  end

  // Reset gates every write so bypass is disabled while reset is asserted.
  assign w0_eff    = reset && w0_en && !(ZERO_REG != 0 && w0_addr == '0);
  assign w1_eff    = reset && w1_en && !(ZERO_REG != 0 && w1_addr == '0);
  assign pend_ok   = pend_set && !(ZERO_REG != 0 && pend_addr == '0);
  assign same_addr = (w0_addr == w1_addr);

  // Port 1 lands first; port 0 merges on top so it wins overlapping lanes.
  assign w1_word = (mem[w1_addr] & ~m1) | (w1_data & m1);
  assign w0_base = (w1_eff && same_addr) ? w1_word : mem[w0_addr];
  assign w0_word = (w0_base & ~m0) | (w0_data & m0);

  always_comb begin
    pend_next = pend;
    if (w1_eff) pend_next[w1_addr] = 1'b0;
    if (w0_eff) pend_next[w0_addr] = 1'b0;
    if (pend_ok) pend_next[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend         <= '0;
      err_conflict <= 1'b0;
    end else begin
      if (w1_eff) mem[w1_addr] <= w1_word;
      if (w0_eff) mem[w0_addr] <= w0_word;
      if (w0_eff && w1_eff && same_addr) err_conflict <= 1'b1;
      pend <= pend_next;
    end
  end

  logic [AW-1:0] ra;
  logic [DW-1:0] rv;
  logic          h0, h1;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    h0      = 1'b0;
    h1      = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      h1 = w1_eff && (w1_addr == ra);
      h0 = w0_eff && (w0_addr == ra);
      rv = mem[ra];
      if (h1) rv = (rv & ~m1) | (w1_data & m1);
      if (h0) rv = (rv & ~m0) | (w0_data & m0);
      if (ZERO_REG != 0 && ra == '0) rv = '0;
      rd_data[k*DW +: DW] = rv;
      rd_busy[k]          = pend[ra] && !(h0 || h1);
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, default and 64-bit/3-port configurations
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_w0_en, a_w1_en, a_pend_set, a_err;
  logic [4:0]   a_w0_addr, a_w1_addr, a_pend_addr;
  logic [3:0]   a_w0_be, a_w1_be;
  logic [31:0]  a_w0_data, a_w1_data;

  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_w0_en, b_w1_en, b_pend_set, b_err;
  logic [3:0]   b_w0_addr, b_w1_addr, b_pend_addr;
  logic [7:0]   b_w0_be, b_w1_be;
  logic [63:0]  b_w0_data, b_w1_data;

  regfile_mp #(.DW(32), .AW(5), .NRD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .w0_en(a_w0_en), .w0_addr(a_w0_addr), .w0_be(a_w0_be), .w0_data(a_w0_data),
    .w1_en(a_w1_en), .w1_addr(a_w1_addr), .w1_be(a_w1_be), .w1_data(a_w1_data),
    .pend_set(a_pend_set), .pend_addr(a_pend_addr), .err_conflict(a_err)
  );

  regfile_mp #(.DW(64), .AW(4), .NRD(3), .ZERO_REG(1)) u_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .w0_en(b_w0_en), .w0_addr(b_w0_addr), .w0_be(b_w0_be), .w0_data(b_w0_data),
    .w1_en(b_w1_en), .w1_addr(b_w1_addr), .w1_be(b_w1_be), .w1_data(b_w1_data),
    .pend_set(b_pend_set), .pend_addr(b_pend_addr), .err_conflict(b_err)
  );

  typedef struct {
    int          kind;
    int          inst;
    int          port;
    logic [63:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_reg  [2][32];
  bit          m_pend [2][32];
  bit          m_err  [2];

  int          s_inst;
  bit          s_rst, s_we0, s_we1, s_ps;
  int          s_a0, s_a1, s_pa;
  logic [7:0]  s_be0, s_be1;
  logic [63:0] s_d0, s_d1;
  int          s_ra [3];

  function automatic int nbytes(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int nports(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic bit eff0();
    return s_rst && s_we0 && s_a0 != 0;
  endfunction

  function automatic bit eff1();
    return s_rst && s_we1 && s_a1 != 0;
  endfunction

  function automatic logic [63:0] model_rd(int a);
    logic [63:0] v;
    v = m_reg[s_inst][a];
    for (int b = 0; b < nbytes(s_inst); b++) begin
      if (eff1() && s_a1 == a && s_be1[b]) v[b*8 +: 8] = s_d1[b*8 +: 8];
      if (eff0() && s_a0 == a && s_be0[b]) v[b*8 +: 8] = s_d0[b*8 +: 8];
    end
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic bit model_busy(int a);
    return m_pend[s_inst][a] && !((eff0() && s_a0 == a) || (eff1() && s_a1 == a));
  endfunction

  task automatic check_now(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clear_stim();
    s_rst = 1'b1; s_we0 = 1'b0; s_we1 = 1'b0; s_ps = 1'b0;
    s_a0 = 0; s_a1 = 0; s_pa = 0; s_be0 = '0; s_be1 = '0; s_d0 = '0; s_d1 = '0;
    s_ra = '{0, 0, 0};
  endtask

  task automatic push(int kind, int port, logic [63:0] exp, string name);
    sb.push_back('{kind, s_inst, port, exp, name});
  endtask

  task automatic issue();
    reset       = s_rst;
    a_w0_en     = (s_inst == 0) && s_we0;
    a_w1_en     = (s_inst == 0) && s_we1;
    a_pend_set  = (s_inst == 0) && s_ps;
    a_w0_addr   = 5'(s_a0); a_w1_addr = 5'(s_a1); a_pend_addr = 5'(s_pa);
    a_w0_be     = s_be0[3:0]; a_w1_be = s_be1[3:0];
    a_w0_data   = s_d0[31:0]; a_w1_data = s_d1[31:0];
    a_rd_addr   = {5'(s_ra[1]), 5'(s_ra[0])};
    b_w0_en     = (s_inst == 1) && s_we0;
    b_w1_en     = (s_inst == 1) && s_we1;
    b_pend_set  = (s_inst == 1) && s_ps;
    b_w0_addr   = 4'(s_a0); b_w1_addr = 4'(s_a1); b_pend_addr = 4'(s_pa);
    b_w0_be     = s_be0; b_w1_be = s_be1;
    b_w0_data   = s_d0; b_w1_data = s_d1;
    b_rd_addr   = {4'(s_ra[2]), 4'(s_ra[1]), 4'(s_ra[0])};
    if (s_rst) begin
      for (int k = 0; k < nports(s_inst); k++) begin
        push(0, k, model_rd(s_ra[k]), "rd_data");
        push(1, k, 64'(model_busy(s_ra[k])), "rd_busy");
      end
      push(2, 0, 64'(m_err[s_inst]), "err_conflict");
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!s_rst) begin
        for (int a = 0; a < 32; a++) begin
          m_reg[i][a]  = '0;
          m_pend[i][a] = 1'b0;
        end
        m_err[i] = 1'b0;
      end else if (i == s_inst) begin
        if (eff0() && eff1() && s_a0 == s_a1) m_err[i] = 1'b1;
        for (int b = 0; b < nbytes(i); b++) begin
          if (eff1() && s_be1[b]) m_reg[i][s_a1][b*8 +: 8] = s_d1[b*8 +: 8];
          if (eff0() && s_be0[b]) m_reg[i][s_a0][b*8 +: 8] = s_d0[b*8 +: 8];
        end
        if (eff1()) m_pend[i][s_a1] = 1'b0;
        if (eff0()) m_pend[i][s_a0] = 1'b0;
        if (s_ps && s_pa != 0) m_pend[i][s_pa] = 1'b1;
      end
    end
    #1;
  endtask

  function automatic int raddr(int inst);
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (inst == 0) ? 31 : 15))
                                       : int'($urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = (e.inst == 0) ? {32'b0, a_rd_data[e.port*32 +: 32]} : b_rd_data[e.port*64 +: 64];
        1:       act = (e.inst == 0) ? 64'(a_rd_busy[e.port]) : 64'(b_rd_busy[e.port]);
        default: act = (e.inst == 0) ? 64'(a_err) : 64'(b_err);
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s inst%0d port%0d t=%0t: got %h expected %h", e.name, e.inst, e.port, $time, act, e.exp);
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    clear_stim(); s_inst = 0; s_rst = 1'b0; issue(); step();

    // reset wipes data, pending and the sticky error
    clear_stim(); s_we0 = 1; s_a0 = 5; s_be0 = 8'hf; s_d0 = 64'hDEADBEEF; s_ps = 1; s_pa = 5; issue(); step();
    clear_stim(); s_ra[0] = 5; issue(); push(0, 0, 64'hDEADBEEF, "r5_written"); push(1, 0, 1, "r5_pending"); step();
    clear_stim(); s_rst = 1'b0; issue(); step();
    clear_stim(); s_ra[0] = 5; issue();
    push(0, 0, 0, "r5_after_reset"); push(1, 0, 0, "busy_after_reset"); push(2, 0, 0, "err_after_reset");
    #1;
    check_now("reset_state_data", {32'b0, a_rd_data[31:0]}, 64'h0);
    check_now("reset_state_busy", 64'(a_rd_busy[0]), 64'h0);
    check_now("reset_state_err", 64'(a_err), 64'h0);
    step();

    // byte-strobe bypass
    clear_stim(); s_we0 = 1; s_a0 = 3; s_be0 = 8'hf; s_d0 = 64'h11223344; issue(); step();
    clear_stim(); s_we0 = 1; s_a0 = 3; s_be0 = 8'b0101; s_d0 = 64'hAABBCCDD; s_ra[0] = 3; issue();
    push(0, 0, 64'h11BB33DD, "bypass_be"); step();
    clear_stim(); s_ra[1] = 3; issue(); push(0, 1, 64'h11BB33DD, "stored_be"); step();

    // same-address double write
    clear_stim(); s_we0 = 1; s_a0 = 7; s_be0 = 8'b0011; s_d0 = 64'h0000AAAA;
    s_we1 = 1; s_a1 = 7; s_be1 = 8'hf; s_d1 = 64'h55555555; s_ra[0] = 7; issue();
    push(0, 0, 64'h5555AAAA, "conflict_bypass"); step();
    for (int c = 0; c < 3; c++) begin
      clear_stim(); s_ra[0] = 7; issue();
      push(0, 0, 64'h5555AAAA, "conflict_stored"); push(2, 0, 1, "err_sticky"); step();
    end

    // pending scoreboard
    clear_stim(); s_ps = 1; s_pa = 9; s_ra[0] = 9; issue(); push(1, 0, 0, "busy_not_yet"); step();
    for (int c = 1; c < 4; c++) begin
      clear_stim(); s_ra[0] = 9; issue(); push(1, 0, 1, "busy_pending"); step();
    end
    clear_stim(); s_we1 = 1; s_a1 = 9; s_be1 = 8'hf; s_d1 = 64'h12345678; s_ra[0] = 9; s_ra[1] = 9; issue();
    push(1, 0, 0, "busy_clear_bypass"); push(0, 1, 64'h12345678, "late_result_bypass"); step();
    clear_stim(); s_ps = 1; s_pa = 9; s_we0 = 1; s_a0 = 9; s_be0 = 8'h0; issue(); step();
    clear_stim(); s_ra[0] = 9; issue(); push(1, 0, 1, "set_wins"); step();
    clear_stim(); s_we0 = 1; s_a0 = 9; s_be0 = 8'h0; s_ra[0] = 9; issue();
    push(1, 0, 0, "be0_clears"); push(0, 0, 64'h12345678, "be0_keeps_data"); step();

    // zero register
    for (int c = 0; c < 3; c++) begin
      clear_stim(); s_we0 = 1; s_a0 = 0; s_be0 = 8'hf; s_d0 = 64'hFFFFFFFF;
      s_we1 = 1; s_a1 = 0; s_be1 = 8'hf; s_d1 = 64'hFFFFFFFF; s_ps = 1; s_pa = 0; issue();
      push(0, 0, 0, "zero_data"); push(0, 1, 0, "zero_data"); push(1, 0, 0, "zero_busy"); step();
    end

    // wide configuration: independent lanes and three read ports
    for (int b = 0; b < 8; b++) begin
      clear_stim(); s_inst = 1; s_we0 = 1; s_a0 = 2; s_be0 = 8'(1 << b); s_d0 = {8{8'(b + 1)}};
      s_we1 = 1; s_a1 = (b % 2) ? 5 : 11; s_be1 = 8'($urandom); s_d1 = {$urandom, $urandom};
      s_ra = '{2, 5, 11}; issue(); step();
    end
    clear_stim(); s_inst = 1; s_ra = '{5, 11, 2}; issue(); push(0, 2, 64'h0807060504030201, "wide_lanes"); step();

    for (int inst = 0; inst < 2; inst++) begin
      for (int n = 0; n < 300; n++) begin
        clear_stim(); s_inst = inst;
        s_rst = ($urandom_range(0, 49) != 0);
        s_we0 = 1'($urandom_range(0, 1)); s_a0 = raddr(inst); s_be0 = 8'($urandom); s_d0 = {$urandom, $urandom};
        s_we1 = 1'($urandom_range(0, 1)); s_a1 = raddr(inst); s_be1 = 8'($urandom); s_d1 = {$urandom, $urandom};
        s_ps = ($urandom_range(0, 3) == 0); s_pa = raddr(inst);
        for (int k = 0; k < 3; k++) s_ra[k] = raddr(inst);
        issue(); step();
      end
    end

    clear_stim(); s_inst = 0; issue(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
